gpioemu_mulpop: RTL and testbench

- Parametrised, clocked successor of the bus-mapped multiply/popcount GPIO emulator.
- Host writes two OP_WIDTH-bit operands over the saddress/srd/swr bus, then writes a start command.
- A multi-cycle shift-add multiplier produces the product; the block then counts ones in the low 32 result bits.
- It reports status, an overflow flag and a completed-operation counter on gpio_out, and latches gpio_in for inspection.

---
 rtl/gpioemu_mulpop.sv | 191 +++++++++++++++++++
 tb/tb_gpioemu_mulpop.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_mulpop.sv
// Bus-mapped GPIO emulator with a multi-cycle shift-add multiplier and popcount of the low product word.
// Optional macro GPIOEMU_MULPOP_HIGH_WORD_EN adds the read-only WH register (product bits above 31).
module gpioemu_mulpop #(
  parameter int unsigned OP_WIDTH  = 24,
  parameter logic [15:0] BASE_ADDR = 16'h0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  localparam int unsigned PW = 2 * OP_WIDTH;
  localparam int unsigned IW = $clog2(OP_WIDTH + 1);

  localparam logic [15:0] ADDR_A1   = BASE_ADDR;
  localparam logic [15:0] ADDR_A2   = BASE_ADDR + 16'h0008;
  localparam logic [15:0] ADDR_W    = BASE_ADDR + 16'h0010;
  localparam logic [15:0] ADDR_L    = BASE_ADDR + 16'h0018;
  localparam logic [15:0] ADDR_CTRL = BASE_ADDR + 16'h0020;
  localparam logic [15:0] ADDR_GPIN = BASE_ADDR + 16'h0028;
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
  localparam logic [15:0] ADDR_WH   = BASE_ADDR + 16'h0030;
`endif

  typedef enum logic [1:0] {IDLE, MULT, COUNT, DONE} state_t;

  state_t state, state_next;

  logic [OP_WIDTH-1:0] a1, a2;
  logic [OP_WIDTH-1:0] mplier;
  logic [PW-1:0]       acc, mcand;
  logic [IW-1:0]       bit_idx;
  logic [31:0]         w;
  logic [5:0]          l;
  logic [5:0]          pop;
  logic                hi_zero;
  logic                ready, valid;
  logic [15:0]         op_count;
  logic [31:0]         gpio_in_s;
  logic                latch_q;
  logic [31:0]         rd_data;
  logic [31:0]         acc_lo, acc_hi;
  logic                start, wr_a1, wr_a2, last_bit;
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
  logic [31:0]         wh;
`endif

  // Upper write-data bits beyond OP_WIDTH are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{sdata_in, 1'b0};

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  assign acc_lo = 32'(acc);

  generate
    if (PW > 32) begin : g_hi
      assign acc_hi = 32'(acc[PW-1:32]);
    end else begin : g_no_hi
      assign acc_hi = '0;
    end
  endgenerate

  assign wr_a1    = swr && ready && (saddress == ADDR_A1);
  assign wr_a2    = swr && ready && (saddress == ADDR_A2);
  assign start    = swr && ready && (saddress == ADDR_CTRL);
  assign last_bit = (bit_idx == IW'(OP_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MULT;
      MULT:    if (last_bit) state_next = COUNT;
      COUNT:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiplier datapath and result/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a1       <= '0;
      a2       <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      bit_idx  <= '0;
      pop      <= '0;
      hi_zero  <= 1'b1;
      w        <= '0;
      l        <= '0;
      ready    <= 1'b1;
      valid    <= 1'b1;
      op_count <= '0;
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
      wh       <= '0;
`endif
    end else begin
      if (wr_a1) a1 <= sdata_in[OP_WIDTH-1:0];
      if (wr_a2) a2 <= sdata_in[OP_WIDTH-1:0];
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            mcand   <= PW'(a1);
            mplier  <= a2;
            bit_idx <= '0;
            ready   <= 1'b0;
          end
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_idx <= bit_idx + IW'(1);
        end
        COUNT: begin
          pop     <= popcount32(acc_lo);
          hi_zero <= (acc_hi == 32'h0);
        end
        DONE: begin
          w        <= acc_lo;
          l        <= pop;
          valid    <= hi_zero;
          ready    <= 1'b1;
          op_count <= op_count + 16'd1;
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
          wh       <= acc_hi;
`endif
        end
        default: ;
      endcase
    end
  end

  // Capture gpio_in only on a sampled 0->1 transition of gpio_latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q   <= 1'b0;
      gpio_in_s <= '0;
    end else begin
      latch_q <= gpio_latch;
      if (gpio_latch && !latch_q) gpio_in_s <= gpio_in;
    end
  end

  always_comb begin
    rd_data = '0;
    case (saddress)
      ADDR_A1:   rd_data = 32'(a1);
      ADDR_A2:   rd_data = 32'(a2);
      ADDR_W:    rd_data = w;
      ADDR_L:    rd_data = {26'b0, l};
      ADDR_CTRL: rd_data = {30'b0, ready, valid};
      ADDR_GPIN: rd_data = gpio_in_s;
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
      ADDR_WH:   rd_data = wh;
`endif
      default:   rd_data = '0;
    endcase
  end

  // Read data holds between reads; reads see pre-edge register values.
  always_ff @(posedge clk) begin
    if (reset)    sdata_out <= '0;
    else if (srd) sdata_out <= rd_data;
  end

  assign gpio_out       = {16'h0, op_count};
  assign gpio_in_s_insp = gpio_in_s;

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Scoreboard bench for gpioemu_mulpop: expected results queued at start, compared on completion.
module tb_gpioemu_mulpop;

  localparam int unsigned OPW = 24;
  localparam logic [15:0] A_A1   = 16'h0380;
  localparam logic [15:0] A_A2   = 16'h0388;
  localparam logic [15:0] A_W    = 16'h0390;
  localparam logic [15:0] A_L    = 16'h0398;
  localparam logic [15:0] A_CTRL = 16'h03A0;
  localparam logic [15:0] A_GPIN = 16'h03A8;
  localparam logic [15:0] A_WH   = 16'h03B0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0, swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_in = '0;
  logic        gpio_latch = 1'b0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in_s_insp;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] w;
    logic [31:0] l;
    logic [31:0] ctrl;
    logic [31:0] cnt;
    logic [31:0] wh;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] cnt_m = '0;

  gpioemu_mulpop #(.OP_WIDTH(OPW), .BASE_ADDR(16'h0380)) dut (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    saddress = addr; sdata_in = data; swr = 1'b1;
    @(posedge clk); #1;
    swr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
    saddress = addr; srd = 1'b1;
    @(posedge clk); #1;
    srd = 1'b0;
    data = sdata_out;
  endtask

  task automatic push_exp(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] prod;
    exp_t e;
    prod   = 64'(a) * 64'(b);
    cnt_m  = cnt_m + 16'd1;
    e.w    = prod[31:0];
    e.l    = 32'($countones(prod[31:0]));
    e.ctrl = {30'b0, 1'b1, prod[63:32] == 32'h0};
    e.cnt  = {16'h0, cnt_m};
    e.wh   = prod[63:32];
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [23:0] a, input logic [23:0] b);
    bus_write(A_A1, 32'(a));
    bus_write(A_A2, 32'(b));
    bus_write(A_CTRL, 32'h0);
    push_exp(a, b);
  endtask

  // Polls CTRL once per cycle; cyc is the number of reads until ready is seen.
  task automatic wait_done(output int cyc);
    logic [31:0] d;
    cyc = 0;
    do begin
      bus_read(A_CTRL, d);
      cyc++;
    end while (!d[1] && cyc < 80);
    tests++;
    if (!d[1]) begin
      fails++;
      $display("FAIL wait_done: ready=%0b after %0d cycles, required 1", d[1], cyc);
    end
  endtask

  task automatic read_result(output logic [31:0] w, output logic [31:0] l, output logic [31:0] c);
    bus_read(A_W, w);
    bus_read(A_L, l);
    bus_read(A_CTRL, c);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    tests++; if (gpio_out !== 32'h0) begin fails++; $display("FAIL reset_gpio_out: got %h want 0", gpio_out); end
    tests++; if (gpio_in_s_insp !== 32'h0) begin fails++; $display("FAIL reset_insp: got %h want 0", gpio_in_s_insp); end
    tests++; if (sdata_out !== 32'h0) begin fails++; $display("FAIL reset_sdata_out: got %h want 0", sdata_out); end
    bus_read(A_CTRL, d);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL reset_ctrl: got %h want 3", d); end
    bus_read(A_W, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_w: got %h want 0", d); end
    bus_read(A_A1, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_a1: got %h want 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] w, l, c, d;
    int cyc;
    exp_t e;
    start_op(24'd3, 24'd5);
    wait_done(cyc);
    e = sb.pop_front();
    read_result(w, l, c);
    tests++; if (w !== e.w) begin fails++; $display("FAIL basic_w: got %h want %h", w, e.w); end
    tests++; if (l !== e.l) begin fails++; $display("FAIL basic_l: got %h want %h", l, e.l); end
    tests++; if (c !== e.ctrl) begin fails++; $display("FAIL basic_ctrl: got %h want %h", c, e.ctrl); end
    tests++; if (gpio_out !== e.cnt) begin fails++; $display("FAIL basic_gpio_out: got %h want %h", gpio_out, e.cnt); end
    // Simultaneous read and write of A1 returns the old value.
    saddress = A_A1; sdata_in = 32'hFF00_004D; srd = 1'b1; swr = 1'b1;
    @(posedge clk); #1;
    srd = 1'b0; swr = 1'b0;
    tests++; if (sdata_out !== 32'h3) begin fails++; $display("FAIL rw_same_cycle: got %h want 3", sdata_out); end
    bus_read(A_A1, d);
    tests++; if (d !== 32'h0000_004D) begin fails++; $display("FAIL a1_truncated: got %h want 0000004d", d); end
    bus_read(16'h0384, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %h want 0", d); end
`ifndef GPIOEMU_MULPOP_HIGH_WORD_EN
    bus_write(A_A1, 32'h0000_0011);
    bus_read(A_WH, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL wh_absent: got %h want 0", d); end
`endif
  endtask

  task automatic test_latency();
    logic [31:0] w, l, c;
    int cyc;
    exp_t e;
    start_op(24'h001234, 24'h000010);
    wait_done(cyc);
    tests++; if (cyc != OPW + 3) begin fails++; $display("FAIL latency: got %0d reads want %0d", cyc, OPW + 3); end
    e = sb.pop_front();
    read_result(w, l, c);
    tests++; if (w !== e.w) begin fails++; $display("FAIL latency_w: got %h want %h", w, e.w); end
  endtask

  task automatic test_busy();
    logic [31:0] w, l, c, d;
    int cyc;
    exp_t e;
    start_op(24'd2, 24'd7);
    idle(4);
    bus_write(A_A1, 32'd9);
    bus_write(A_CTRL, 32'h0);
    bus_read(A_CTRL, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL busy_ctrl: got %h want 1", d); end
    wait_done(cyc);
    e = sb.pop_front();
    read_result(w, l, c);
    tests++; if (w !== e.w) begin fails++; $display("FAIL busy_w: got %h want %h", w, e.w); end
    bus_read(A_A1, d);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL busy_a1_kept: got %h want 2", d); end
    idle(35);
    tests++; if (gpio_out !== e.cnt) begin fails++; $display("FAIL busy_no_restart: got %h want %h", gpio_out, e.cnt); end
  endtask

  task automatic test_max();
    logic [31:0] w, l, c;
    int cyc;
    exp_t e;
    start_op(24'hFFFFFF, 24'hFFFFFF);
    wait_done(cyc);
    e = sb.pop_front();
    read_result(w, l, c);
    tests++; if (w !== e.w) begin fails++; $display("FAIL max_w: got %h want %h", w, e.w); end
    tests++; if (l !== e.l) begin fails++; $display("FAIL max_l: got %h want %h", l, e.l); end
    tests++; if (c !== e.ctrl) begin fails++; $display("FAIL max_ctrl: got %h want %h", c, e.ctrl); end
`ifdef GPIOEMU_MULPOP_HIGH_WORD_EN
    begin
      logic [31:0] h;
      bus_read(A_WH, h);
      tests++; if (h !== e.wh) begin fails++; $display("FAIL max_wh: got %h want %h", h, e.wh); end
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, l, c, d;
    int cyc;
    exp_t e;
    start_op(24'd5, 24'd6);
    idle(9);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    sb.delete();
    cnt_m = '0;
    read_result(w, l, c);
    tests++; if (w !== 32'h0) begin fails++; $display("FAIL abort_w: got %h want 0", w); end
    tests++; if (l !== 32'h0) begin fails++; $display("FAIL abort_l: got %h want 0", l); end
    tests++; if (c !== 32'h3) begin fails++; $display("FAIL abort_ctrl: got %h want 3", c); end
    tests++; if (gpio_out !== 32'h0) begin fails++; $display("FAIL abort_gpio_out: got %h want 0", gpio_out); end
    bus_read(A_A1, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL abort_a1: got %h want 0", d); end
    start_op(24'd4, 24'd4);
    wait_done(cyc);
    e = sb.pop_front();
    read_result(w, l, c);
    tests++; if (w !== e.w) begin fails++; $display("FAIL after_abort_w: got %h want %h", w, e.w); end
    tests++; if (gpio_out !== e.cnt) begin fails++; $display("FAIL after_abort_cnt: got %h want %h", gpio_out, e.cnt); end
  endtask

  task automatic test_wrap();
    logic [31:0] w, l, c;
    int cyc;
    exp_t e;
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    @(posedge clk); #1;
    tests++; if (gpio_out !== 32'h0000_FFFF) begin fails++; $display("FAIL wrap_preload: got %h want 0000ffff", gpio_out); end
    cnt_m = 16'hFFFF;
    start_op(24'd1, 24'd1);
    wait_done(cyc);
    e = sb.pop_front();
    read_result(w, l, c);
    tests++; if (gpio_out !== e.cnt) begin fails++; $display("FAIL wrap_cnt: got %h want %h", gpio_out, e.cnt); end
    tests++; if (w !== e.w) begin fails++; $display("FAIL wrap_w: got %h want %h", w, e.w); end
  endtask

  task automatic test_gpio();
    logic [31:0] d;
    gpio_in = 32'hA5A5_0001;
    gpio_latch = 1'b0;
    idle(2);
    gpio_latch = 1'b1;
    idle(1);
    gpio_in = 32'h1234_5678;
    idle(3);
    tests++; if (gpio_in_s_insp !== 32'hA5A5_0001) begin fails++; $display("FAIL gpio_hold_insp: got %h want a5a50001", gpio_in_s_insp); end
    bus_read(A_GPIN, d);
    tests++; if (d !== 32'hA5A5_0001) begin fails++; $display("FAIL gpio_hold_read: got %h want a5a50001", d); end
    gpio_latch = 1'b0;
    idle(1);
    gpio_latch = 1'b1;
    idle(1);
    tests++; if (gpio_in_s_insp !== 32'h1234_5678) begin fails++; $display("FAIL gpio_recapture: got %h want 12345678", gpio_in_s_insp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_busy();
    test_max();
    test_reset_mid();
    test_wrap();
    test_gpio();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
